// File: rtl/mem_responder_if.sv
// mem_responder_if: core-side dcache/icache request bus plus stall.
interface mem_responder_if;
  logic [31:0] dcache_addr;
  logic [3:0]  dcache_we;
  logic        dcache_re;
  logic [31:0] dcache_din;
  logic [31:0] dcache_dout;
  logic [31:0] icache_addr;
  logic [3:0]  icache_we;
  logic        icache_re;
  logic [31:0] icache_din;
  logic [31:0] instruction;
  logic        stall;
  modport master (
    output dcache_addr, dcache_we, dcache_re, dcache_din,
    output icache_addr, icache_we, icache_re, icache_din,
    input  dcache_dout, instruction, stall
  );
  modport slave (
    input  dcache_addr, dcache_we, dcache_re, dcache_din,
    input  icache_addr, icache_we, icache_re, icache_din,
    output dcache_dout, instruction, stall
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: unified word RAM serving data and instruction ports with modelled stall latency.
module mem_responder #(
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 3
) (
  input logic           clk,
  input logic           rst,
  mem_responder_if.slave bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WAIT_D = 2'd1;
  localparam logic [1:0] WAIT_I = 2'd2;
  localparam bit         ZERO   = (LATENCY == 0);
  localparam logic [3:0] CNT_LD = 4'(ZERO ? 0 : LATENCY - 1);
  logic [31:0] mem [2**ADDR_WIDTH];
  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic ipend_q, ipend_d, stall_q, stall_d;
  logic [31:0] dout_q, dout_d, instr_q, instr_d;
  logic [ADDR_WIDTH-1:0] dl_idx_q, dl_idx_d, il_idx_q, il_idx_d;
  logic [3:0] dl_we_q, dl_we_d, il_we_q, il_we_d;
  logic dl_re_q, dl_re_d, il_re_q, il_re_d;
  logic [31:0] dl_din_q, dl_din_d, il_din_q, il_din_d;
  logic idle, done, d_act, i_act, d_re_c, i_re_c;
  logic [ADDR_WIDTH-1:0] d_idx_c, i_idx_c;
  logic [3:0] d_we_c, i_we_c;
  logic [31:0] d_din_c, i_din_c, dw, iw;
  // Zero latency serves ports directly from IDLE; otherwise the latched request completes when cnt hits 0.
  always_comb begin
    idle     = state_q == IDLE;
    done     = !idle && cnt_q == 4'd0;
    d_act    = bus.dcache_re || bus.dcache_we != 4'd0;
    i_act    = bus.icache_re || bus.icache_we != 4'd0;
    d_idx_c  = idle ? bus.dcache_addr[ADDR_WIDTH+1:2] : dl_idx_q;
    i_idx_c  = idle ? bus.icache_addr[ADDR_WIDTH+1:2] : il_idx_q;
    d_din_c  = idle ? bus.dcache_din : dl_din_q;
    i_din_c  = idle ? bus.icache_din : il_din_q;
    d_we_c   = (idle && ZERO) ? bus.dcache_we : (done && state_q == WAIT_D) ? dl_we_q : 4'd0;
    i_we_c   = (idle && ZERO) ? bus.icache_we : (done && state_q == WAIT_I) ? il_we_q : 4'd0;
    d_re_c   = (idle && ZERO) ? bus.dcache_re : done && state_q == WAIT_D && dl_re_q;
    i_re_c   = (idle && ZERO) ? bus.icache_re : done && state_q == WAIT_I && il_re_q;
    dw       = mem[d_idx_c];
    iw       = mem[i_idx_c];
    for (int b = 0; b < 4; b++) begin
      if (i_we_c[b] && i_idx_c == d_idx_c) dw[8*b+:8] = i_din_c[8*b+:8];
      if (i_we_c[b]) iw[8*b+:8] = i_din_c[8*b+:8];
    end
    for (int b = 0; b < 4; b++) begin
      if (d_we_c[b]) dw[8*b+:8] = d_din_c[8*b+:8];
      if (d_we_c[b] && i_idx_c == d_idx_c) iw[8*b+:8] = d_din_c[8*b+:8];
    end
    dout_d   = d_re_c ? dw : dout_q;
    instr_d  = i_re_c ? iw : instr_q;
    dl_idx_d = idle ? bus.dcache_addr[ADDR_WIDTH+1:2] : dl_idx_q;
    dl_we_d  = idle ? bus.dcache_we : dl_we_q;
    dl_re_d  = idle ? bus.dcache_re : dl_re_q;
    dl_din_d = idle ? bus.dcache_din : dl_din_q;
    il_idx_d = idle ? bus.icache_addr[ADDR_WIDTH+1:2] : il_idx_q;
    il_we_d  = idle ? bus.icache_we : il_we_q;
    il_re_d  = idle ? bus.icache_re : il_re_q;
    il_din_d = idle ? bus.icache_din : il_din_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    ipend_d  = ipend_q;
    stall_d  = stall_q;
    if (idle) begin
      if (!ZERO && (d_act || i_act)) begin
        state_d = d_act ? WAIT_D : WAIT_I;
        cnt_d   = CNT_LD;
        ipend_d = d_act && i_act;
        stall_d = 1'b1;
      end
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end else if (ipend_q) begin
      state_d = WAIT_I;
      cnt_d   = CNT_LD;
      ipend_d = 1'b0;
    end else begin
      state_d = IDLE;
      stall_d = 1'b0;
    end
  end
  // D bytes are written last so they win when both ports hit the same byte.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int b = 0; b < 4; b++)
        if (i_we_c[b]) mem[i_idx_c][8*b+:8] <= i_din_c[8*b+:8];
      for (int b = 0; b < 4; b++)
        if (d_we_c[b]) mem[d_idx_c][8*b+:8] <= d_din_c[8*b+:8];
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ipend_q  <= 1'b0;
      stall_q  <= 1'b0;
      dout_q   <= '0;
      instr_q  <= '0;
      dl_idx_q <= '0;
      dl_we_q  <= '0;
      dl_re_q  <= 1'b0;
      dl_din_q <= '0;
      il_idx_q <= '0;
      il_we_q  <= '0;
      il_re_q  <= 1'b0;
      il_din_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ipend_q  <= ipend_d;
      stall_q  <= stall_d;
      dout_q   <= dout_d;
      instr_q  <= instr_d;
      dl_idx_q <= dl_idx_d;
      dl_we_q  <= dl_we_d;
      dl_re_q  <= dl_re_d;
      dl_din_q <= dl_din_d;
      il_idx_q <= il_idx_d;
      il_we_q  <= il_we_d;
      il_re_q  <= il_re_d;
      il_din_q <= il_din_d;
    end
  end
  assign bus.stall       = stall_q;
  assign bus.dcache_dout = dout_q;
  assign bus.instruction = instr_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed and random checks of latency-3 and latency-0 responders against a word-map model.
module tb_mem_responder;
  logic clk = 1'b0, rst3, rst0;
  always #5 clk = ~clk;
  mem_responder_if b3 ();
  mem_responder_if b0 ();
  mem_responder #(.ADDR_WIDTH(12), .LATENCY(3)) u3 (.clk(clk), .rst(rst3), .bus(b3.slave));
  mem_responder #(.ADDR_WIDTH(12), .LATENCY(0)) u0 (.clk(clk), .rst(rst0), .bus(b0.slave));
  int nchk = 0, nerr = 0;
  logic [31:0] m3 [int];
  logic [31:0] m0 [int];
  logic [31:0] e3d = 0, e3i = 0, e0d = 0, e0i = 0;

  function automatic logic [31:0] mask(input logic [31:0] old, input logic [3:0] we, input logic [31:0] din);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (we[b]) r[8*b+:8] = din[8*b+:8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One request on the latency-3 responder: model applies D then I in order, then stall length and outputs are checked.
  task automatic acc3(input logic [3:0] dwe, input logic dre, input logic [31:0] da, input logic [31:0] dd,
                      input logic [3:0] iwe, input logic ire, input logic [31:0] ia, input logic [31:0] id,
                      input string tag);
    int dk = int'(da[13:2]), ik = int'(ia[13:2]), n = 0, want;
    logic da_act = dre || dwe != 0, ia_act = ire || iwe != 0;
    want = 3 * (int'(da_act) + int'(ia_act));
    if (da_act) begin
      m3[dk] = mask(m3.exists(dk) ? m3[dk] : 32'd0, dwe, dd);
      if (dre) e3d = m3[dk];
    end
    if (ia_act) begin
      m3[ik] = mask(m3.exists(ik) ? m3[ik] : 32'd0, iwe, id);
      if (ire) e3i = m3[ik];
    end
    b3.dcache_we = dwe; b3.dcache_re = dre; b3.dcache_addr = da; b3.dcache_din = dd;
    b3.icache_we = iwe; b3.icache_re = ire; b3.icache_addr = ia; b3.icache_din = id;
    @(posedge clk);
    #1;
    b3.dcache_we = 0; b3.dcache_re = 0; b3.icache_we = 0; b3.icache_re = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!b3.stall) break;
      n++;
    end
    chk({tag, ".stall_len"}, 32'(n), 32'(want));
    chk({tag, ".dout"}, b3.dcache_dout, e3d);
    chk({tag, ".instr"}, b3.instruction, e3i);
  endtask

  // One cycle on the latency-0 responder: I write then D write (D wins), both reads see the final word.
  task automatic acc0(input logic [3:0] dwe, input logic dre, input logic [31:0] da, input logic [31:0] dd,
                      input logic [3:0] iwe, input logic ire, input logic [31:0] ia, input logic [31:0] id,
                      input string tag);
    int dk = int'(da[13:2]), ik = int'(ia[13:2]);
    if (iwe != 0) m0[ik] = mask(m0.exists(ik) ? m0[ik] : 32'd0, iwe, id);
    if (dwe != 0) m0[dk] = mask(m0.exists(dk) ? m0[dk] : 32'd0, dwe, dd);
    if (dre) e0d = m0[dk];
    if (ire) e0i = m0[ik];
    b0.dcache_we = dwe; b0.dcache_re = dre; b0.dcache_addr = da; b0.dcache_din = dd;
    b0.icache_we = iwe; b0.icache_re = ire; b0.icache_addr = ia; b0.icache_din = id;
    @(negedge clk);
    chk({tag, ".stall0"}, {31'd0, b0.stall}, 32'd0);
    chk({tag, ".dout0"}, b0.dcache_dout, e0d);
    chk({tag, ".instr0"}, b0.instruction, e0i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] dwe, iwe;
    logic [31:0] da, ia;
    b3.dcache_we = 0; b3.dcache_re = 0; b3.dcache_addr = 0; b3.dcache_din = 0;
    b3.icache_we = 0; b3.icache_re = 0; b3.icache_addr = 0; b3.icache_din = 0;
    b0.dcache_we = 0; b0.dcache_re = 0; b0.dcache_addr = 0; b0.dcache_din = 0;
    b0.icache_we = 0; b0.icache_re = 0; b0.icache_addr = 0; b0.icache_din = 0;
    rst3 = 1; rst0 = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst3 = 0; rst0 = 0;
    chk("rst.stall3", {31'd0, b3.stall}, 32'd0);
    chk("rst.dout3", b3.dcache_dout, 32'd0);
    chk("rst.instr3", b3.instruction, 32'd0);
    chk("rst.stall0", {31'd0, b0.stall}, 32'd0);
    chk("rst.dout0", b0.dcache_dout, 32'd0);
    chk("rst.instr0", b0.instruction, 32'd0);
    acc3(4'hF, 0, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, "wr10");
    acc3(0, 1, 32'h10, 0, 0, 0, 0, 0, "rd10");
    acc3(4'hF, 0, 32'h20, 32'h11223344, 0, 0, 0, 0, "wr20");
    acc3(4'b0010, 0, 32'h20, 32'h0000AA00, 0, 0, 0, 0, "bytemask");
    acc3(0, 1, 32'h20, 0, 0, 0, 0, 0, "rd20");
    chk("bytemask.value", b3.dcache_dout, 32'h1122AA44);
    acc3(0, 1, 32'h10, 0, 0, 1, 32'h20, 0, "dual");
    acc3(4'hF, 0, 32'h40, 32'hCAFEF00D, 0, 1, 32'h40, 0, "hazard");
    chk("hazard.value", b3.instruction, 32'hCAFEF00D);
    for (int k = 0; k < 8; k++) acc3(4'hF, 0, 32'h100 + 32'(4 * k), $urandom, 0, 0, 0, 0, "pool");
    for (int k = 0; k < 20; k++) begin
      dwe = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
      iwe = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
      da = 32'h100 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
      ia = 32'h100 + 32'(4 * $urandom_range(0, 7));
      acc3(dwe, 1'($urandom), da, $urandom, iwe, 1'($urandom), ia, $urandom, "rand");
    end
    acc3(4'hF, 0, 32'h50, 32'h11111111, 0, 0, 0, 0, "wr50");
    b3.dcache_we = 4'hF; b3.dcache_addr = 32'h50; b3.dcache_din = 32'h12345678;
    @(posedge clk);
    #1;
    b3.dcache_we = 0;
    @(posedge clk);
    #1;
    rst3 = 1;
    #1;
    chk("midrst.stall", {31'd0, b3.stall}, 32'd0);
    chk("midrst.dout", b3.dcache_dout, 32'd0);
    chk("midrst.instr", b3.instruction, 32'd0);
    e3d = 0; e3i = 0;
    @(posedge clk);
    @(negedge clk);
    rst3 = 0;
    @(negedge clk);
    chk("midrst.idle", {31'd0, b3.stall}, 32'd0);
    acc3(0, 1, 32'h50, 0, 0, 0, 0, 0, "rd50");
    chk("midrst.old", b3.dcache_dout, 32'h11111111);
    for (int k = 0; k < 4; k++) acc0(4'hF, 0, 32'h10 + 32'(4 * k), $urandom, 0, 0, 0, 0, "l0wr");
    for (int k = 0; k < 4; k++) acc0(0, 1, 32'h10 + 32'(4 * k), 0, 0, 1, 32'h1C - 32'(4 * k), 0, "l0rd");
    acc0(4'hF, 1, 32'h30, 32'hAAAAAAAA, 4'hF, 1, 32'h30, 32'h55555555, "l0same");
    chk("l0same.value", b0.instruction, 32'hAAAAAAAA);
    acc0(4'b0011, 1, 32'h30, 32'h0000BBBB, 4'b1100, 1, 32'h30, 32'hCCCC0000, "l0merge");
    acc0(0, 0, 0, 0, 0, 0, 0, 0, "l0hold");
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
